// File: rtl/pong_pkg.sv
// Shared types for the pong match controller.
// MATCH_CTRL_PAUSE_EN adds the PAUSE state.
package pong_pkg;

   localparam int SCORE_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_RALLY = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
`ifdef MATCH_CTRL_PAUSE_EN
      ,
      ST_PAUSE = 3'd5
`endif
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } winner_t;

endpackage

// File: rtl/match_ctrl_serve_timer.sv
// Serve delay: counts frame ticks while enabled, done on the last one.
module serve_timer #(
   parameter int TICKS = 60
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic tick,
   output logic done
);

   localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

   logic [CW-1:0] cnt;

   assign done = en & tick & (cnt == CW'(TICKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || done) begin
         cnt <= '0;
      end else if (en && tick) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencer: serve delay, goal scoring, game over.
// Define MATCH_CTRL_PAUSE_EN for the pause_btn input and PAUSE state.
module match_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_TICKS = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic               goal_left,
   input  logic               goal_right,
`ifdef MATCH_CTRL_PAUSE_EN
   input  logic               pause_btn,
`endif
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic               ball_reset,
   output logic               ball_en,
   output logic               serve_dir,
   output logic [1:0]         winner,
   output logic [2:0]         state_o
);

   localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] WIN_M1 = SCORE_W'(WIN_SCORE - 1);

   state_t state, nxt;
   logic   gl_q, gl_p, gr_q, gr_p;
   logic   start_q;
   logic   gl_edge, gr_edge, start_edge;
   logic   pause_edge;
   logic   p1_pt;
   logic   pulse_q;
   logic   last_pt;
   logic   tmr_clr, tmr_en, tmr_done;

   assign gl_edge    = gl_q & ~gl_p;
   assign gr_edge    = gr_q & ~gr_p;
   assign start_edge = start_btn & ~start_q;
   assign last_pt    = (p1_pt ? p1_score : p2_score) == WIN_M1;

`ifdef MATCH_CTRL_PAUSE_EN
   state_t saved;
   logic   pause_q;
   assign pause_edge = pause_btn & ~pause_q;
   assign tmr_clr    = !(state inside {ST_SERVE, ST_PAUSE});
`else
   assign pause_edge = 1'b0;
   assign tmr_clr    = state != ST_SERVE;
`endif
   // a tick coinciding with a pause edge must not advance the count
   assign tmr_en = (state == ST_SERVE) && !pause_edge;

   serve_timer #(.TICKS(SERVE_TICKS)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (tmr_clr),
      .en   (tmr_en),
      .tick (frame_tick),
      .done (tmr_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         ST_IDLE:  if (start_btn) nxt = ST_SERVE;
         ST_SERVE: begin
`ifdef MATCH_CTRL_PAUSE_EN
            if (pause_edge)    nxt = ST_PAUSE;
            else
`endif
            if (tmr_done)      nxt = ST_RALLY;
         end
         ST_RALLY: begin
`ifdef MATCH_CTRL_PAUSE_EN
            if (pause_edge)    nxt = ST_PAUSE;
            else
`endif
            if (gl_edge && gr_edge)      nxt = ST_SERVE;
            else if (gl_edge || gr_edge) nxt = ST_POINT;
         end
         ST_POINT: nxt = last_pt ? ST_OVER : ST_SERVE;
         ST_OVER:  if (start_edge) nxt = ST_SERVE;
`ifdef MATCH_CTRL_PAUSE_EN
         ST_PAUSE: if (pause_edge) nxt = saved;
`endif
         default:  nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ball_en    = state == ST_RALLY;
      ball_reset = (state == ST_POINT) | pulse_q;
      winner     = WIN_NONE;
      if (state == ST_OVER) winner = p1_pt ? WIN_P1 : WIN_P2;
      state_o    = state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gl_q      <= 1'b0;
         gl_p      <= 1'b0;
         gr_q      <= 1'b0;
         gr_p      <= 1'b0;
         start_q   <= 1'b0;
         pulse_q   <= 1'b0;
         p1_pt     <= 1'b0;
         serve_dir <= 1'b0;
         p1_score  <= '0;
         p2_score  <= '0;
      end else begin
         gl_q    <= goal_left;
         gl_p    <= gl_q;
         gr_q    <= goal_right;
         gr_p    <= gr_q;
         start_q <= start_btn;
         // re-centre on match start and on a simultaneous double goal
         pulse_q <= (nxt == ST_SERVE) &&
                    (state inside {ST_IDLE, ST_OVER, ST_RALLY});
         if ((state inside {ST_IDLE, ST_OVER}) && nxt == ST_SERVE) begin
            p1_score <= '0;
            p2_score <= '0;
         end
         if (state == ST_RALLY && nxt == ST_POINT) p1_pt <= gr_edge;
         if (state == ST_POINT) begin
            serve_dir <= p1_pt;
            if (p1_pt && p1_score < WIN)
               p1_score <= p1_score + SCORE_W'(1);
            if (!p1_pt && p2_score < WIN)
               p2_score <= p2_score + SCORE_W'(1);
         end
      end
   end

`ifdef MATCH_CTRL_PAUSE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pause_q <= 1'b0;
         saved   <= ST_SERVE;
      end else begin
         pause_q <= pause_btn;
         if (nxt == ST_PAUSE && state != ST_PAUSE) saved <= state;
      end
   end
`endif

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: vector table, directed corners,
// randomized run against a behavioural match model.
module tb_match_ctrl;
   import pong_pkg::*;

   localparam int WS = 2;
   localparam int ST = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       goal_left = 1'b0;
   logic       goal_right = 1'b0;
`ifdef MATCH_CTRL_PAUSE_EN
   logic       pause_btn = 1'b0;
`endif
   logic [3:0] p1_score, p2_score;
   logic       ball_reset, ball_en, serve_dir;
   logic [1:0] winner;
   logic [2:0] state_o;

   int n_vec = 0;
   int n_bad = 0;

   match_ctrl #(.WIN_SCORE(WS), .SERVE_TICKS(ST)) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .start_btn  (start_btn),
      .goal_left  (goal_left),
      .goal_right (goal_right),
`ifdef MATCH_CTRL_PAUSE_EN
      .pause_btn  (pause_btn),
`endif
      .p1_score   (p1_score),
      .p2_score   (p2_score),
      .ball_reset (ball_reset),
      .ball_en    (ball_en),
      .serve_dir  (serve_dir),
      .winner     (winner),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   // behavioural match model
   state_t m_mode;
   int     m_p1, m_p2, m_ticks, m_who;
   logic   m_dir, m_pulse, m_s;
   logic   m_gl1, m_gl2, m_gr1, m_gr2;

   task automatic model_reset();
      m_mode = ST_IDLE; m_p1 = 0; m_p2 = 0; m_ticks = 0; m_who = 0;
      m_dir = 0; m_pulse = 0; m_s = 0;
      m_gl1 = 0; m_gl2 = 0; m_gr1 = 0; m_gr2 = 0;
   endtask

   task automatic model_step(input logic s, t, gl, gr);
      logic el, er, sr;
      el = m_gl1 & ~m_gl2;
      er = m_gr1 & ~m_gr2;
      sr = s & ~m_s;
      m_gl2 = m_gl1; m_gl1 = gl;
      m_gr2 = m_gr1; m_gr1 = gr;
      m_s = s;
      m_pulse = 0;
      case (m_mode)
         ST_IDLE: if (s) begin
            m_mode = ST_SERVE; m_p1 = 0; m_p2 = 0; m_ticks = 0; m_pulse = 1;
         end
         ST_SERVE: if (t) begin
            m_ticks++;
            if (m_ticks == ST) m_mode = ST_RALLY;
         end
         ST_RALLY: if (el && er) begin
            m_mode = ST_SERVE; m_ticks = 0; m_pulse = 1;
         end else if (el || er) begin
            m_mode = ST_POINT; m_who = er ? 1 : 2;
         end
         ST_POINT: begin
            if (m_who == 1 && m_p1 < WS) m_p1++;
            if (m_who == 2 && m_p2 < WS) m_p2++;
            m_dir = (m_who == 1);
            m_ticks = 0;
            m_mode = (m_p1 == WS || m_p2 == WS) ? ST_OVER : ST_SERVE;
         end
         ST_OVER: if (sr) begin
            m_mode = ST_SERVE; m_p1 = 0; m_p2 = 0; m_ticks = 0; m_pulse = 1;
         end
         default: m_mode = ST_IDLE;
      endcase
   endtask

   function automatic logic [15:0] pack(logic [2:0] st, logic [3:0] a, b,
                                        logic br, en, dir, logic [1:0] w);
      return {st, a, b, br, en, dir, w};
   endfunction

   function automatic logic [15:0] dut_vec();
      return pack(state_o, p1_score, p2_score, ball_reset, ball_en,
                  serve_dir, winner);
   endfunction

   function automatic logic [15:0] model_vec();
      logic [1:0] w;
      w = 2'b00;
      if (m_mode == ST_OVER) w = (m_p1 == WS) ? 2'b01 : 2'b10;
      return pack(m_mode, 4'(m_p1), 4'(m_p2), m_pulse | (m_mode == ST_POINT),
                  m_mode == ST_RALLY, m_dir, w);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got st/p1/p2/br/en/dir/win=%h required %h",
                  name, act, exp);
      end
   endtask

   task automatic apply(input logic s, t, gl, gr);
      start_btn = s; frame_tick = t; goal_left = gl; goal_right = gr;
      @(posedge clk);
      model_step(s, t, gl, gr);
      #2;
   endtask

   typedef struct {
      logic [3:0] in;
      state_t     st;
      int         p1, p2;
      logic       br, en, dir;
      logic [1:0] w;
   } vec_t;

   function automatic vec_t mk(logic [3:0] in, state_t st, int p1, p2,
                               logic br, en, dir, logic [1:0] w);
      vec_t v;
      v.in = in; v.st = st; v.p1 = p1; v.p2 = p2;
      v.br = br; v.en = en; v.dir = dir; v.w = w;
      return v;
   endfunction

   vec_t tv[38];

   initial begin
      // in = {start, tick, goal_left, goal_right}
      tv[0]  = mk(4'b1000, ST_SERVE, 0, 0, 1, 0, 0, 0);
      tv[1]  = mk(4'b0100, ST_SERVE, 0, 0, 0, 0, 0, 0);
      tv[2]  = mk(4'b0100, ST_SERVE, 0, 0, 0, 0, 0, 0);
      tv[3]  = mk(4'b0000, ST_SERVE, 0, 0, 0, 0, 0, 0);
      tv[4]  = mk(4'b0100, ST_RALLY, 0, 0, 0, 1, 0, 0);
      tv[5]  = mk(4'b0001, ST_RALLY, 0, 0, 0, 1, 0, 0);
      tv[6]  = mk(4'b0001, ST_POINT, 0, 0, 1, 0, 0, 0);
      tv[7]  = mk(4'b0001, ST_SERVE, 1, 0, 0, 0, 1, 0);
      tv[8]  = mk(4'b0101, ST_SERVE, 1, 0, 0, 0, 1, 0);
      tv[9]  = mk(4'b0101, ST_SERVE, 1, 0, 0, 0, 1, 0);
      tv[10] = mk(4'b0101, ST_RALLY, 1, 0, 0, 1, 1, 0);
      tv[11] = mk(4'b0001, ST_RALLY, 1, 0, 0, 1, 1, 0);
      tv[12] = mk(4'b0001, ST_RALLY, 1, 0, 0, 1, 1, 0);
      tv[13] = mk(4'b0001, ST_RALLY, 1, 0, 0, 1, 1, 0);
      tv[14] = mk(4'b0001, ST_RALLY, 1, 0, 0, 1, 1, 0);
      tv[15] = mk(4'b0000, ST_RALLY, 1, 0, 0, 1, 1, 0);
      tv[16] = mk(4'b0000, ST_RALLY, 1, 0, 0, 1, 1, 0);
      tv[17] = mk(4'b0011, ST_RALLY, 1, 0, 0, 1, 1, 0);
      tv[18] = mk(4'b0011, ST_SERVE, 1, 0, 1, 0, 1, 0);
      tv[19] = mk(4'b0000, ST_SERVE, 1, 0, 0, 0, 1, 0);
      tv[20] = mk(4'b0100, ST_SERVE, 1, 0, 0, 0, 1, 0);
      tv[21] = mk(4'b0100, ST_SERVE, 1, 0, 0, 0, 1, 0);
      tv[22] = mk(4'b0100, ST_RALLY, 1, 0, 0, 1, 1, 0);
      tv[23] = mk(4'b0010, ST_RALLY, 1, 0, 0, 1, 1, 0);
      tv[24] = mk(4'b0000, ST_POINT, 1, 0, 1, 0, 1, 0);
      tv[25] = mk(4'b0000, ST_SERVE, 1, 1, 0, 0, 0, 0);
      tv[26] = mk(4'b0100, ST_SERVE, 1, 1, 0, 0, 0, 0);
      tv[27] = mk(4'b0100, ST_SERVE, 1, 1, 0, 0, 0, 0);
      tv[28] = mk(4'b0100, ST_RALLY, 1, 1, 0, 1, 0, 0);
      tv[29] = mk(4'b0010, ST_RALLY, 1, 1, 0, 1, 0, 0);
      tv[30] = mk(4'b0000, ST_POINT, 1, 1, 1, 0, 0, 0);
      tv[31] = mk(4'b0000, ST_OVER,  1, 2, 0, 0, 0, 2);
      tv[32] = mk(4'b0001, ST_OVER,  1, 2, 0, 0, 0, 2);
      tv[33] = mk(4'b0000, ST_OVER,  1, 2, 0, 0, 0, 2);
      tv[34] = mk(4'b0010, ST_OVER,  1, 2, 0, 0, 0, 2);
      tv[35] = mk(4'b0000, ST_OVER,  1, 2, 0, 0, 0, 2);
      tv[36] = mk(4'b1000, ST_SERVE, 0, 0, 1, 0, 0, 0);
      tv[37] = mk(4'b1000, ST_SERVE, 0, 0, 0, 0, 0, 0);

      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("reset", dut_vec(), pack(ST_IDLE, 0, 0, 0, 0, 0, 2'b00));
      rst = 1'b0;

      for (int i = 0; i < 38; i++) begin
         apply(tv[i].in[3], tv[i].in[2], tv[i].in[1], tv[i].in[0]);
         chk($sformatf("table[%0d]", i), dut_vec(),
             pack(tv[i].st, 4'(tv[i].p1), 4'(tv[i].p2), tv[i].br,
                  tv[i].en, tv[i].dir, tv[i].w));
      end

      // reset landing on the POINT cycle
      begin
         bit seen;
         seen = 0;
         for (int i = 0; i < ST; i++) apply(0, 1, 0, 0);
         apply(0, 0, 0, 1);
         for (int i = 0; i < 10 && !seen; i++) begin
            apply(0, 0, 0, 0);
            if (state_o == ST_POINT) seen = 1;
         end
         if (!seen) begin
            n_vec++; n_bad++;
            $display("FAIL point_wait: POINT not reached within 10 cycles");
         end
         rst = 1'b1;
         #1;
         chk("rst_in_point", dut_vec(), pack(ST_IDLE, 0, 0, 0, 0, 0, 2'b00));
         @(posedge clk);
         #2;
         chk("rst_held", dut_vec(), pack(ST_IDLE, 0, 0, 0, 0, 0, 2'b00));
         rst = 1'b0;
         model_reset();
      end

      // randomized run against the model
      begin
         logic s, gl, gr;
         s = 0; gl = 0; gr = 0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) s = ~s;
            if ($urandom_range(3) == 0) gl = ~gl;
            if ($urandom_range(3) == 0) gr = ~gr;
            apply(s, $urandom_range(2) == 0, gl, gr);
            chk("random", dut_vec(), model_vec());
         end
      end

`ifdef MATCH_CTRL_PAUSE_EN
      // pause with one serve tick left, ticks while paused are ignored
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      apply(1, 0, 0, 0);
      apply(0, 1, 0, 0);
      apply(0, 1, 0, 0);
      pause_btn = 1'b1;
      apply(0, 0, 0, 0);
      chk("pause_enter", {13'd0, state_o}, {13'd0, ST_PAUSE});
      pause_btn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         apply(0, 1, 0, 0);
         chk("pause_hold", {12'd0, ball_en, state_o}, {13'd0, ST_PAUSE});
      end
      pause_btn = 1'b1;
      apply(0, 0, 0, 0);
      chk("pause_exit", {13'd0, state_o}, {13'd0, ST_SERVE});
      pause_btn = 1'b0;
      apply(0, 0, 0, 0);
      chk("serve_wait", {13'd0, state_o}, {13'd0, ST_SERVE});
      apply(0, 1, 0, 0);
      chk("serve_done", {12'd0, ball_en, state_o}, {13'd1, ST_RALLY});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7: points needed to win; legal range 1..15.
REQ-002 SHALL have parameter SERVE_TICKS, default 60: frame_tick pulses counted in SERVE before the ball is released.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port frame_tick, input, 1: one-cycle pulse, once per video frame.
REQ-006 SHALL have port start_btn, input, 1: level input, already synchronised; starts or restarts a match.
REQ-007 SHALL have port goal_left, input, 1: level input; ball crossed the left edge, so player 2 scores.
REQ-008 SHALL have port goal_right, input, 1: level input; ball crossed the right edge, so player 1 scores.
REQ-009 SHALL have port p1_score, output, 4: player 1 score.
REQ-010 SHALL have port p2_score, output, 4: player 2 score.
REQ-011 SHALL have port ball_reset, output, 1: one-cycle pulse that re-centres the ball.
REQ-012 SHALL have port ball_en, output, 1: ball motion enable; high only in RALLY.
REQ-013 SHALL have port serve_dir, output, 1: 0 = serve toward player 1 (left), 1 = serve toward player 2 (right).
REQ-014 SHALL have port winner, output, 2: 00 = none, 01 = player 1, 10 = player 2.
REQ-015 SHALL have port state_o, output, 3: current FSM state encoding, for debug.

Function
REQ-016 SHALL implement the states IDLE, SERVE, RALLY, POINT and GAMEOVER.
REQ-017 SHALL move IDLE->SERVE on start_btn high, zeroing both scores and pulsing ball_reset in the same transition.
REQ-018 SHALL, in SERVE, count frame_tick pulses and move to RALLY on the SERVE_TICKS-th pulse; frame_tick is ignored in every other state.
REQ-019 SHALL register each goal input once and detect its rising edge; a held goal level counts as one event only.
REQ-020 SHALL act on goal edges only in RALLY; edges arriving in any other state are discarded.
REQ-021 SHALL, in RALLY, move to POINT on a single goal edge, recording the scorer; latency is 2 cycles from the goal input rising edge to state_o = POINT.
REQ-022 SHALL, on both goal edges in the same cycle, award no point, pulse ball_reset, keep serve_dir unchanged and move to SERVE.
REQ-023 SHALL, in POINT (one cycle): increment the scorer's score, with the new value visible the next cycle; pulse ball_reset; set serve_dir toward the player who conceded.
REQ-024 SHALL leave POINT for GAMEOVER if the incremented score equals WIN_SCORE, otherwise for SERVE.
REQ-025 SHALL never increment a score past WIN_SCORE.
REQ-026 SHALL, in GAMEOVER, hold the scores, drive winner nonzero and hold ball_en low; a start_btn rising edge re-enters SERVE with the scores cleared and winner = 00.
REQ-027 SHALL keep winner = 00 in every state other than GAMEOVER.

Reset
REQ-028 SHALL, on rst, asynchronously force: state IDLE; p1_score = p2_score = 0; ball_reset = 0; ball_en = 0; serve_dir = 0; winner = 00; serve counter = 0; goal edge registers = 0.
REQ-029 SHALL behave identically on rst asserted mid-RALLY or mid-POINT: no partial score update survives.

Configuration
REQ-030 SHALL, with macro MATCH_CTRL_PAUSE_EN defined, add input pause_btn (1 bit) and state PAUSE.
- A pause_btn rising edge in SERVE or RALLY enters PAUSE.
- In PAUSE: ball_en = 0, serve counter frozen, goal edges discarded.
- The next pause_btn rising edge returns to the saved state.
- start_btn is ignored in PAUSE.
REQ-031 SHALL, without MATCH_CTRL_PAUSE_EN, have no pause_btn port and no PAUSE state; all other behaviour is unchanged.

Structure
REQ-032 SHALL take the state enum, the winner codes and SCORE_W = 4 from shared package pong_pkg.
REQ-033 SHALL contain one sub-module, serve_timer: the frame_tick counter with clear, enable and done outputs.

Verification
REQ-034 SHALL cover: reset, start_btn pulse, SERVE_TICKS = 3, three frame_ticks -> ball_en = 1 after the third tick; scores 0/0.
REQ-035 SHALL cover: in RALLY, goal_right held high for 10 cycles -> p1_score = 1 exactly once, one ball_reset pulse, serve_dir = 1.
REQ-036 SHALL cover: goal_left and goal_right rising in the same cycle -> scores unchanged, state SERVE, serve_dir unchanged.
REQ-037 SHALL cover: WIN_SCORE = 2, two player-2 points -> p2_score = 2, winner = 10, GAMEOVER; further goal edges leave the scores unchanged.
REQ-038 SHALL cover: rst asserted the cycle state_o = POINT -> scores 0/0, IDLE, no ball_reset pulse.
REQ-039 SHALL cover, with MATCH_CTRL_PAUSE_EN: pause in SERVE with 1 tick remaining, then 5 frame_ticks, then unpause -> RALLY only after the next frame_tick.
